// File: rtl/tpm_ram_arbiter.sv
// Shares the single-port TPM command/response RAM between the Wishbone slave and the
// LPC data-provider byte port. Owner-first priority with a starvation counter for the non-owner.
module tpm_ram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  exec_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    input  logic                  dp_req_i,
    input  logic                  dp_we_i,
    input  logic [ADDR_WIDTH-1:0] dp_addr_i,
    input  logic [7:0]            dp_wdata_i,
    output logic [7:0]            dp_rdata_o,
    output logic                  dp_ack_o,
    output logic [ADDR_WIDTH-3:0] ram_a_o,
    output logic [31:0]           ram_wd_o,
    output logic [3:0]            ram_wen_o,
    input  logic [31:0]           ram_rd_i,
    output logic                  busy_o
);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACC, ACK} state_e;

    state_e                state_q, state_d;
    logic                  gnt_wb_q, gnt_wb_d;
    logic                  gnt_dp_q, gnt_dp_d;
    logic [1:0]            lane_q, lane_d;
    logic [7:0]            wait_q, wait_d;
    logic                  exec_q;
    logic [ADDR_WIDTH-3:0] ram_a_q, ram_a_d;
    logic [31:0]           ram_wd_q, ram_wd_d;
    logic [3:0]            ram_wen_q, ram_wen_d;

    logic       in_ack, wb_ack, dp_ack;
    logic       wb_pend, dp_pend, own_pend, non_pend;
    logic       non_win, pick_wb, pick_dp;
    logic [7:0] wait_eff;
    logic       unused_adr;

    assign unused_adr = ^{wb_adr_i[1:0]};

    assign in_ack = (state_q == ACK);
    assign wb_ack = in_ack & gnt_wb_q & wb_cyc_i;
    assign dp_ack = in_ack & gnt_dp_q;

    always_comb begin
        wb_pend  = wb_cyc_i & wb_stb_i & ~wb_ack;
        dp_pend  = dp_req_i & ~dp_ack;
        own_pend = exec_i ? wb_pend : dp_pend;
        non_pend = exec_i ? dp_pend : wb_pend;
        // An ownership flip restarts the starvation count for the new non-owner.
        wait_eff = (exec_i != exec_q) ? 8'd0 : wait_q;
        non_win  = non_pend & (~own_pend | (wait_eff == MAX_W));
        pick_wb  = exec_i ? (own_pend & ~non_win) : non_win;
        pick_dp  = exec_i ? non_win : (own_pend & ~non_win);
    end

    always_comb begin
        state_d   = state_q;
        gnt_wb_d  = gnt_wb_q;
        gnt_dp_d  = gnt_dp_q;
        lane_d    = lane_q;
        ram_a_d   = ram_a_q;
        ram_wd_d  = ram_wd_q;
        ram_wen_d = 4'b0000;
        wait_d    = non_pend ? wait_eff : 8'd0;
        case (state_q)
            IDLE: begin
                if (non_win)
                    wait_d = 8'd0;
                else if (non_pend)
                    wait_d = (wait_eff == MAX_W) ? wait_eff : wait_eff + 8'd1;
                if (pick_wb) begin
                    state_d   = ACC;
                    gnt_wb_d  = 1'b1;
                    gnt_dp_d  = 1'b0;
                    ram_a_d   = wb_adr_i[ADDR_WIDTH-1:2];
                    ram_wd_d  = wb_dat_i;
                    ram_wen_d = wb_we_i ? wb_sel_i : 4'b0000;
                end else if (pick_dp) begin
                    state_d   = ACC;
                    gnt_wb_d  = 1'b0;
                    gnt_dp_d  = 1'b1;
                    lane_d    = dp_addr_i[1:0];
                    ram_a_d   = dp_addr_i[ADDR_WIDTH-1:2];
                    ram_wd_d  = {4{dp_wdata_i}};
                    ram_wen_d = dp_we_i ? (4'b0001 << dp_addr_i[1:0]) : 4'b0000;
                end
            end
            ACC: state_d = ACK;
            ACK: begin
                state_d  = IDLE;
                gnt_wb_d = 1'b0;
                gnt_dp_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            gnt_wb_q  <= 1'b0;
            gnt_dp_q  <= 1'b0;
            lane_q    <= 2'd0;
            wait_q    <= 8'd0;
            exec_q    <= 1'b0;
            ram_a_q   <= '0;
            ram_wd_q  <= 32'd0;
            ram_wen_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            gnt_wb_q  <= gnt_wb_d;
            gnt_dp_q  <= gnt_dp_d;
            lane_q    <= lane_d;
            wait_q    <= wait_d;
            exec_q    <= exec_i;
            ram_a_q   <= ram_a_d;
            ram_wd_q  <= ram_wd_d;
            ram_wen_q <= ram_wen_d;
        end
    end

    assign wb_ack_o   = wb_ack;
    assign dp_ack_o   = dp_ack;
    assign wb_dat_o   = (in_ack & gnt_wb_q) ? ram_rd_i : 32'd0;
    assign dp_rdata_o = (in_ack & gnt_dp_q) ? ram_rd_i[{lane_q, 3'b000} +: 8] : 8'd0;
    assign ram_a_o    = ram_a_q;
    assign ram_wd_o   = ram_wd_q;
    assign ram_wen_o  = ram_wen_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_tpm_ram_arbiter.sv
// Scoreboard bench for tpm_ram_arbiter: byte-array shadow memory, per-port expectation queues,
// directed latency/arbitration/abort/reset scenarios and randomized concurrent traffic.
module tb_tpm_ram_arbiter;
    localparam int AW = 11;
    localparam int MW = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i, exec_i;
    logic [AW-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i, wb_dat_o;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
    logic          dp_req_i, dp_we_i, dp_ack_o;
    logic [AW-1:0] dp_addr_i;
    logic [7:0]    dp_wdata_i, dp_rdata_o;
    logic [AW-3:0] ram_a_o;
    logic [31:0]   ram_wd_o, ram_rd_i;
    logic [3:0]    ram_wen_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    tpm_ram_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .exec_i(exec_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .dp_req_i(dp_req_i), .dp_we_i(dp_we_i), .dp_addr_i(dp_addr_i), .dp_wdata_i(dp_wdata_i),
        .dp_rdata_o(dp_rdata_o), .dp_ack_o(dp_ack_o),
        .ram_a_o(ram_a_o), .ram_wd_o(ram_wd_o), .ram_wen_o(ram_wen_o), .ram_rd_i(ram_rd_i),
        .busy_o(busy_o)
    );

    // RAM with one-cycle registered read and byte write enables
    logic [31:0] mem [0:(1<<(AW-2))-1];
    initial begin
        logic [31:0] w;
        for (int i = 0; i < (1<<(AW-2)); i++) mem[i] <= 32'd0;
        ram_rd_i <= 32'd0;
        forever begin
            @(posedge clk_i);
            ram_rd_i <= mem[ram_a_o];
            w = mem[ram_a_o];
            for (int b = 0; b < 4; b++)
                if (ram_wen_o[b]) w[8*b +: 8] = ram_wd_o[8*b +: 8];
            mem[ram_a_o] <= w;
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [31:0]   data;
        logic [3:0]    sel;
        int            issue;
    } txn_t;

    txn_t wb_q[$];
    txn_t dp_q[$];
    txn_t commit_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d expected <= %0d (cycle %0d)", nm, act, lim, cyc);
        end
    endtask

    // Reference model: byte-addressed buffer, updated in acknowledge order
    logic [7:0] shadow [0:(1<<AW)-1];

    function automatic logic [31:0] shadow_word(input logic [AW-1:0] a);
        int base;
        base = int'(a[AW-1:2]) * 4;
        return {shadow[base+3], shadow[base+2], shadow[base+1], shadow[base]};
    endfunction

    initial begin
        txn_t t;
        int   lat;
        for (int i = 0; i < (1<<AW); i++) shadow[i] = 8'd0;
        forever begin
            @(negedge clk_i);
            while (commit_q.size() > 0) begin
                t = commit_q.pop_front();
                for (int b = 0; b < 4; b++)
                    if (t.sel[b]) shadow[int'(t.addr[AW-1:2])*4 + b] = t.data[8*b +: 8];
            end
            if (wb_ack_o) begin
                if (wb_q.size() == 0) chk("wb_unexpected_ack", 32'd1, 32'd0);
                else begin
                    t = wb_q.pop_front();
                    lat = cyc - t.issue;
                    chk_le("wb_latency", lat, exec_i ? 8 : 3*MW+6);
                    if (!t.we) chk("wb_rdata", wb_dat_o, shadow_word(t.addr));
                    else
                        for (int b = 0; b < 4; b++)
                            if (t.sel[b]) shadow[int'(t.addr[AW-1:2])*4 + b] = t.data[8*b +: 8];
                end
            end
            if (dp_ack_o) begin
                if (dp_q.size() == 0) chk("dp_unexpected_ack", 32'd1, 32'd0);
                else begin
                    t = dp_q.pop_front();
                    lat = cyc - t.issue;
                    chk_le("dp_latency", lat, exec_i ? 3*MW+6 : 8);
                    if (!t.we) chk("dp_rdata", {24'd0, dp_rdata_o}, {24'd0, shadow[int'(t.addr)]});
                    else shadow[int'(t.addr)] = t.data[7:0];
                end
            end
        end
    end

    task automatic wb_issue(input logic [AW-1:0] a, input logic we, input logic [31:0] d,
                            input logic [3:0] s, input logic track);
        txn_t t;
        wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = s;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        t.addr = a; t.we = we; t.data = d; t.sel = s; t.issue = cyc;
        if (track) wb_q.push_back(t);
    endtask

    task automatic dp_issue(input logic [AW-1:0] a, input logic we, input logic [7:0] d,
                            input logic track);
        txn_t t;
        dp_addr_i = a; dp_we_i = we; dp_wdata_i = d; dp_req_i = 1'b1;
        t.addr = a; t.we = we; t.data = {24'd0, d}; t.sel = 4'd0; t.issue = cyc;
        if (track) dp_q.push_back(t);
    endtask

    task automatic wb_wait(output int ack_cyc);
        ack_cyc = -1;
        for (int n = 0; n < 60 && ack_cyc < 0; n++) begin
            @(negedge clk_i);
            if (wb_ack_o) ack_cyc = cyc;
        end
        if (ack_cyc < 0) chk("wb_ack_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic dp_wait(output int ack_cyc);
        ack_cyc = -1;
        for (int n = 0; n < 60 && ack_cyc < 0; n++) begin
            @(negedge clk_i);
            if (dp_ack_o) ack_cyc = cyc;
        end
        if (ack_cyc < 0) chk("dp_ack_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        dp_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, a1, a2, da, nack;
        int   wa [0:5];
        txn_t ct;
        rstn_i = 1'b0; exec_i = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        dp_req_i = 1'b0; dp_we_i = 1'b0; dp_addr_i = '0; dp_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_wen", {28'd0, ram_wen_o}, 32'd0);
        chk("rst_acks", {30'd0, wb_ack_o, dp_ack_o}, 32'd0);
        chk("rst_ram_a", {23'd0, ram_a_o}, 32'd0);
        chk("rst_ram_wd", ram_wd_o, 32'd0);
        chk("rst_rdata", wb_dat_o | {24'd0, dp_rdata_o}, 32'd0);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Full-word WB write then read back
        exec_i = 1'b1;
        wb_issue(11'h010, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
        t0 = cyc;
        @(negedge clk_i); @(negedge clk_i);
        chk("t1_wen_acc", {28'd0, ram_wen_o}, 32'hF);
        wb_wait(a1);
        chk("t1_ack_latency", a1 - t0, 2);
        wb_issue(11'h010, 1'b0, 32'd0, 4'h0, 1'b1);
        wb_wait(a1);

        // DP byte write lands in lane 2, seen by WB word read and DP byte read
        exec_i = 1'b0;
        dp_issue(11'h006, 1'b1, 8'hA5, 1'b1);
        @(negedge clk_i); @(negedge clk_i);
        chk("t2_wen_lane", {28'd0, ram_wen_o}, 32'h4);
        chk("t2_wd_replicated", ram_wd_o, 32'hA5A5A5A5);
        dp_wait(da);
        wb_issue(11'h004, 1'b0, 32'd0, 4'h0, 1'b1);
        wb_wait(a1);
        dp_issue(11'h006, 1'b0, 8'h00, 1'b1);
        dp_wait(da);

        // Simultaneous requests: owner first, non-owner one slot later
        exec_i = 1'b1;
        t0 = cyc;
        wb_issue(11'h020, 1'b1, 32'h12345678, 4'hF, 1'b1);
        dp_issue(11'h021, 1'b0, 8'h00, 1'b1);
        fork
            wb_wait(a1);
            dp_wait(a2);
        join
        chk("t3_wb_ack", a1 - t0, 2);
        chk("t3_dp_ack", a2 - t0, 5);

        // Starvation: owner back-to-back, non-owner forced in after MAX_WAIT losses
        t0 = cyc;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    wb_issue(11'(16*k), 1'b1, $urandom, 4'hF, 1'b1);
                    wb_wait(wa[k]);
                end
            end
            begin
                dp_issue(11'h011, 1'b1, 8'h5A, 1'b1);
                dp_wait(da);
            end
        join
        chk("t4_wb3_ack", wa[3] - t0, 3*3+2);
        chk("t4_dp_forced", da - t0, 3*MW+2);
        chk("t4_wb4_after_dp", wa[4] - t0, 3*(MW+1)+2);

        // WB cycle dropped during ACC: write commits, no ack
        wb_issue(11'h030, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0);
        ct.addr = 11'h030; ct.we = 1'b1; ct.data = 32'hCAFEF00D; ct.sel = 4'hF; ct.issue = cyc;
        commit_q.push_back(ct);
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        nack = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (wb_ack_o) nack++;
        end
        chk("t5_ack_suppressed", nack, 0);
        @(posedge clk_i); #1;
        wb_issue(11'h030, 1'b0, 32'd0, 4'h0, 1'b1);
        wb_wait(a1);

        // Reset during ACC of a DP write
        exec_i = 1'b0;
        wb_issue(11'h008, 1'b1, 32'h11223344, 4'hF, 1'b1);
        wb_wait(a1);
        dp_issue(11'h009, 1'b1, 8'h3C, 1'b0);
        @(posedge clk_i); #1;
        chk("t6_wen_pre", {28'd0, ram_wen_o}, 32'h2);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("t6_wen_reset", {28'd0, ram_wen_o}, 32'h0);
        chk("t6_busy_reset", {31'd0, busy_o}, 32'd0);
        dp_req_i = 1'b0;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        nack = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (dp_ack_o) nack++;
        end
        chk("t6_no_dp_ack", nack, 0);
        @(posedge clk_i); #1;
        wb_issue(11'h008, 1'b0, 32'd0, 4'h0, 1'b1);
        wb_wait(a1);

        // Randomized concurrent traffic, each ownership
        for (int ph = 0; ph < 2; ph++) begin
            exec_i = (ph == 0);
            fork
                begin
                    int ac;
                    for (int i = 0; i < 40; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
                        wb_issue(11'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                                 $urandom, 4'($urandom_range(0, 15)), 1'b1);
                        wb_wait(ac);
                    end
                end
                begin
                    int ac;
                    for (int i = 0; i < 40; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
                        dp_issue(11'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                                 8'($urandom), 1'b1);
                        dp_wait(ac);
                    end
                end
            join
        end

        repeat (5) @(posedge clk_i);
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("dp_queue_drained", dp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
